tt_and_bist: RTL

Built-in self-test sequencer for the registered 8-bit AND core behind the `tt_um_and` tile. It drives pseudo-random operand pairs into the core's `a`/`b` inputs and aligns the expected result to the core latency. It compares the core's `Y` output every cycle, then reports a pass/fail verdict and a saturating error count. It sits beside the core inside the tile wrapper. The wrapper muxes tile pins between external operands and BIST operands.

---
 rtl/tt_and_bist_pkg.sv | 24 ++
 rtl/tt_and_bist_lfsr.sv | 36 +++
 rtl/tt_and_bist.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tt_and_bist_pkg.sv
// Shared types and constants for the tt_and_bist self-test sequencer.
// The LFSR step lives here so the generator and its consumers agree on the polynomial.
package tt_and_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [7:0]  ERR_SAT = 8'd255;
    localparam logic [9:0]  NO_ERR  = 10'h3FF;

    // Fibonacci step, shifting left: new bit 0 is s[15]^s[13]^s[12]^s[10]
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tt_and_bist_lfsr.sv
// 16-bit operand generator for the BIST: loadable with the seed, advances one step when enabled.
module tt_and_bist_lfsr
    import tt_and_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (shift_en) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tt_and_bist.sv
// BIST sequencer for the registered 8-bit AND core: issues LFSR operands, delays the
// expected result by the core latency, and accumulates a saturating mismatch count.
module tt_and_bist
    import tt_and_bist_pkg::*;
#(
    parameter int                LATENCY = 1,
    parameter int                NUM_VEC = 16,
    parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    input  logic [7:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [9:0] first_err
);

    localparam logic [9:0] LAST_IDX   = 10'(NUM_VEC - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(LATENCY - 1);

    bist_state_e state_q, state_d;
    logic [9:0]  vec_idx_q, vec_idx_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]  a_out_q, a_out_d;
    logic [7:0]  b_out_q, b_out_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [9:0]  first_err_q, first_err_d;

    logic        line_valid_q [LATENCY];
    logic        line_valid_d [LATENCY];
    logic [7:0]  line_exp_q   [LATENCY];
    logic [7:0]  line_exp_d   [LATENCY];
    logic [9:0]  line_idx_q   [LATENCY];
    logic [9:0]  line_idx_d   [LATENCY];

    logic              lfsr_load;
    logic              lfsr_shift;
    logic [LFSR_W-1:0] lfsr_state;
    logic              start_accept;
    logic              tail_mismatch;

    tt_and_bist_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .shift_en (lfsr_shift),
        .state    (lfsr_state)
    );

    assign start_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

    // Operands are registered one step ahead of the LFSR so vector i appears with state i
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        drain_cnt_d = drain_cnt_q;
        a_out_d     = 8'd0;
        b_out_d     = 8'd0;
        lfsr_load   = 1'b0;
        lfsr_shift  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    state_d   = ST_RUN;
                    vec_idx_d = 10'd0;
                    lfsr_load = 1'b1;
                    a_out_d   = SEED[15:8];
                    b_out_d   = SEED[7:0];
                end
            end
            ST_RUN: begin
                if (vec_idx_q == LAST_IDX) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 3'd0;
                end else begin
                    vec_idx_d  = vec_idx_q + 10'd1;
                    lfsr_shift = 1'b1;
                    {a_out_d, b_out_d} = lfsr_step(lfsr_state);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        line_valid_d[0] = (state_q == ST_RUN);
        line_exp_d[0]   = a_out_q & b_out_q;
        line_idx_d[0]   = vec_idx_q;
        for (int i = 1; i < LATENCY; i++) begin
            line_valid_d[i] = line_valid_q[i-1];
            line_exp_d[i]   = line_exp_q[i-1];
            line_idx_d[i]   = line_idx_q[i-1];
        end
    end

    assign tail_mismatch = line_valid_q[LATENCY-1] && (y_in != line_exp_q[LATENCY-1]);

    always_comb begin
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        if (start_accept) begin
            err_count_d = 8'd0;
            first_err_d = NO_ERR;
        end else if (tail_mismatch) begin
            if (err_count_q != ERR_SAT) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (first_err_q == NO_ERR) begin
                first_err_d = line_idx_q[LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_idx_q   <= 10'd0;
            drain_cnt_q <= 3'd0;
            a_out_q     <= 8'd0;
            b_out_q     <= 8'd0;
            err_count_q <= 8'd0;
            first_err_q <= NO_ERR;
            for (int i = 0; i < LATENCY; i++) begin
                line_valid_q[i] <= 1'b0;
                line_exp_q[i]   <= 8'd0;
                line_idx_q[i]   <= 10'd0;
            end
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            drain_cnt_q <= drain_cnt_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            for (int i = 0; i < LATENCY; i++) begin
                line_valid_q[i] <= line_valid_d[i];
                line_exp_q[i]   <= line_exp_d[i];
                line_idx_q[i]   <= line_idx_d[i];
            end
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = (state_q == ST_DONE) && (err_count_q == 8'd0);
    assign err_count = err_count_q;
    assign first_err = first_err_q;

endmodule
